// File: rtl/exec_trace_buffer.sv
// Execution-trace capture and run-control unit: records PC, instruction and writeback
// every RUN cycle into a circular buffer with a cycle stamp, read out show-ahead.
module exec_trace_buffer #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 16,
    parameter int CNT_W      = 16,
    parameter int MAX_CYCLES = 20,
    parameter int WRAP       = 0,
    parameter int FILTER_WR  = 0
) (
    input  logic                     clock,
    input  logic                     resetN,
    input  logic                     arm,
    input  logic                     clear,
    input  logic [ADDR_W-1:0]        pcQ,
    input  logic [DATA_W-1:0]        instruction,
    input  logic                     regWriteEnable,
    input  logic [4:0]               writeReg,
    input  logic [DATA_W-1:0]        writeData,
    input  logic                     breakEn,
    input  logic [ADDR_W-1:0]        breakAddr,
    input  logic                     rdReady,
    output logic                     rdValid,
    output logic [CNT_W-1:0]         rdCycle,
    output logic [ADDR_W-1:0]        rdPc,
    output logic [DATA_W-1:0]        rdInstr,
    output logic [DATA_W+5:0]        rdWr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     running,
    output logic [1:0]               stopReason,
    output logic [CNT_W-1:0]         dropped,
    output logic [1:0]               dbgState
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int WR_W    = DATA_W + 6;
    localparam int ENTRY_W = CNT_W + ADDR_W + DATA_W + WR_W;
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);
    localparam logic [1:0] REASON_NONE = 2'd0;
    localparam logic [1:0] REASON_BREAK = 2'd1;
    localparam logic [1:0] REASON_TIMEOUT = 2'd2;
    localparam logic [1:0] REASON_FULL = 2'd3;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOPPED = 2'd2} traceState;

    traceState state, stateNext;
    logic [1:0]         reasonNext;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wrPtr, rdPtr;
    logic [CNT_W-1:0]   cycleCnt;
    logic [PTR_W:0]     countNext;
    logic               isFull, capture, doPop, doPush, overwrite;
    logic               breakHit, timeoutHit, fullHit;
    logic [CNT_W-1:0]   headCycle;
    logic [ADDR_W-1:0]  headPc;
    logic [DATA_W-1:0]  headInstr;
    logic [WR_W-1:0]    headWr;

    assign isFull   = (count == FULL_COUNT);
    assign capture  = (state == RUN) && ((FILTER_WR == 0) || regWriteEnable);
    assign doPop    = rdValid && rdReady;
    // Without wrap a full buffer refuses new entries unless the head leaves this cycle.
    assign doPush   = capture && !clear && !((WRAP == 0) && isFull && !doPop);
    assign overwrite = doPush && (WRAP != 0) && isFull && !doPop;
    assign breakHit  = breakEn && (pcQ == breakAddr);
    assign timeoutHit = (MAX_CYCLES != 0) && (cycleCnt == LAST_CYCLE);
    assign fullHit   = (WRAP == 0) && capture && (countNext == FULL_COUNT);

    always_comb begin
        countNext = count;
        if (clear)
            countNext = '0;
        else if (overwrite)
            countNext = count;
        else if (doPush && !doPop)
            countNext = count + (PTR_W+1)'(1);
        else if (!doPush && doPop)
            countNext = count - (PTR_W+1)'(1);
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            stopReason <= REASON_NONE;
        end else begin
            state      <= stateNext;
            stopReason <= reasonNext;
        end
    end

    always_comb begin
        stateNext  = state;
        reasonNext = arm ? REASON_NONE : stopReason;
        case (state)
            IDLE, STOPPED: if (arm) stateNext = RUN;
            RUN: begin
                // Priority of simultaneous stop causes: BREAK > TIMEOUT > FULL.
                if (!arm) begin
                    if (breakHit) begin
                        stateNext  = STOPPED;
                        reasonNext = REASON_BREAK;
                    end else if (timeoutHit) begin
                        stateNext  = STOPPED;
                        reasonNext = REASON_TIMEOUT;
                    end else if (fullHit) begin
                        stateNext  = STOPPED;
                        reasonNext = REASON_FULL;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        running  = (state == RUN);
        dbgState = state;
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            cycleCnt <= '0;
            dropped  <= '0;
        end else begin
            if (clear) begin
                wrPtr <= '0;
                rdPtr <= '0;
            end else begin
                if (doPush) wrPtr <= wrPtr + PTR_W'(1);
                if (doPop || overwrite) rdPtr <= rdPtr + PTR_W'(1);
            end
            count <= countNext;
            if (arm)
                cycleCnt <= '0;
            else if (state == RUN)
                cycleCnt <= cycleCnt + CNT_W'(1);
            if (arm)
                dropped <= '0;
            else if (overwrite && (dropped != '1))
                dropped <= dropped + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (doPush)
            mem[wrPtr] <= {cycleCnt, pcQ, instruction, regWriteEnable, writeReg, writeData};
    end

    assign {headCycle, headPc, headInstr, headWr} = mem[rdPtr];
    assign rdValid = (count != '0);
    assign rdCycle = rdValid ? headCycle : '0;
    assign rdPc    = rdValid ? headPc : '0;
    assign rdInstr = rdValid ? headInstr : '0;
    assign rdWr    = rdValid ? headWr : '0;
endmodule

// File: doc/exec_trace_buffer.md
# exec_trace_buffer

Parametrised execution-trace capture and run-control unit for the single-cycle DataPath. It samples the PC, instruction and register-writeback signals every clock, stores them with a cycle stamp in a circular buffer, and stops capture on a cycle limit, a PC breakpoint or a full buffer. Stored entries are read out through a valid/ready port. It generalises the bench-side "display every cycle, stop after N cycles" debug flow into synthesizable hardware with configurable depth, filtering and wrap mode.

## Interface
- ADDR_W, 32, PC width
- DATA_W, 32, instruction and writeback data width
- DEPTH, 16, number of trace entries; power of 2, ≥2
- CNT_W, 16, width of cycle stamp and dropped counter
- MAX_CYCLES, 20, timeout in RUN cycles; 0 disables timeout
- WRAP, 0, 0 = stop when full, 1 = overwrite oldest entry
- FILTER_WR, 0, 1 = capture only cycles with regWriteEnable=1
- clock  in  1  single clock; all state updates on rising edge
- resetN  in  1  asynchronous, active-low reset
- arm  in  1  pulse: enter RUN, clear cycle count/stopReason/dropped
- clear  in  1  empty the buffer (pointers and count to 0)
- pcQ  in  ADDR_W  current PC
- instruction  in  DATA_W  current instruction
- regWriteEnable  in  1  register-file write strobe
- writeReg  in  5  destination register index
- writeData  in  DATA_W  writeback value
- breakEn  in  1  enable the PC breakpoint
- breakAddr  in  ADDR_W  breakpoint PC
- rdReady  in  1  consumer accepts the head entry
- rdValid  out  1  head entry available (count≠0)
- rdCycle  out  CNT_W  cycle stamp of the head entry
- rdPc  out  ADDR_W  PC of the head entry
- rdInstr  out  DATA_W  instruction of the head entry
- rdWr  out  1+5+DATA_W  {regWriteEnable, writeReg, writeData} of the head entry
- count  out  log2(DEPTH)+1  entries held
- running  out  1  state==RUN
- stopReason  out  2  0 none, 1 BREAK, 2 TIMEOUT, 3 FULL
- dropped  out  CNT_W  entries overwritten in WRAP mode; saturates

## Operation
- FSM states: IDLE, RUN, STOPPED. Reset enters IDLE.
- IDLE/STOPPED with arm=1 → RUN. Cycle count is 0. stopReason and dropped are 0. The buffer is not cleared by arm.
- arm while in RUN restarts the cycle count at 0 and stays in RUN.
- RUN: cycle count increments every cycle. Capture happens when FILTER_WR=0 or regWriteEnable=1.
  - Each entry is {cycle count, pcQ, instruction, regWriteEnable, writeReg, writeData}, written at wrPtr.
- Breakpoint: in RUN, breakEn=1 and pcQ==breakAddr. That cycle is still captured if the filter passes. Next state is STOPPED with reason BREAK.
- Timeout: in RUN with MAX_CYCLES≠0 and cycle count==MAX_CYCLES-1. That cycle is captured. Next state is STOPPED with reason TIMEOUT.
- Full when WRAP=0: a capture that makes count==DEPTH leads to STOPPED with reason FULL.
- Full when WRAP=1: a capture while count==DEPTH and no pop overwrites the oldest entry. rdPtr advances, count stays DEPTH, and dropped increments.
- Simultaneous stop causes: priority BREAK > TIMEOUT > FULL.
- Pop occurs when rdValid && rdReady. rdPtr advances and count decrements. The pop is legal in any state.
- Push and pop in the same cycle: count is unchanged. When full, there is no drop.
- clear takes priority over the same-cycle push and pop. After clear, count=0 and both pointers are 0. The FSM state is unaffected.
- Pointers wrap modulo DEPTH. The cycle count wraps modulo 2^CNT_W.

## Timing
- Asynchronous reset (resetN=0) values: state IDLE, count 0, pointers 0, running 0, stopReason 0, dropped 0, rdValid 0. rd* data outputs are 0.
- Capture latency: an entry sampled at edge k is visible at the head at edge k+1 if the buffer was empty. rdValid rises the cycle after the push.
- Read port is show-ahead. rd* outputs are combinational from the array at rdPtr and are valid whenever rdValid=1. The next entry appears the cycle after a pop.
- running falls on the edge after the stopping cycle. No capture occurs in STOPPED.
- Reset asserted mid-RUN aborts immediately and discards all entries.

## Test plan
- Default params, arm at cycle 0, no reads → 16 entries with stamps 0..15. stopReason=FULL after the 16th capture, running=0.
- DEPTH=32, MAX_CYCLES=20, arm → exactly 20 entries with stamps 0..19. stopReason=TIMEOUT. The entry-20 PC is absent.
- breakEn=1, breakAddr=0x0000000C, PC stepping by 4 from 0 → 4 entries with PCs 0,4,8,C. stopReason=BREAK.
- WRAP=1, MAX_CYCLES=40, rdReady=0 → count=16, head stamp=24, dropped=24. Popping all entries yields stamps 24..39.
- FILTER_WR=1, regWriteEnable high on cycles 2,5,9 only → 3 entries stamped 2,5,9 with the matching writeReg/writeData.
- rdReady=1 throughout RUN → count stays ≤1. clear pulsed with a push and pop in the same cycle leaves count=0. resetN low mid-RUN drops running and rdValid immediately.
